// File: rtl/line_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_pkg                                                                   |
// | Shared geometry constants and sequencer state encoding for line drawing.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package line_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_START     = 4'd2,
        ST_ARM       = 4'd3,
        ST_WAIT      = 4'd4,
        ST_NEXT      = 4'd5,
        ST_CLR_LOAD  = 4'd6,
        ST_CLR_START = 4'd7,
        ST_CLR_ARM   = 4'd8,
        ST_CLR_WAIT  = 4'd9
    } seq_state_t;

    // Decision taken in IDLE and after each segment: a clear beats drawing.
    function automatic seq_state_t pick_next(input logic clear_req, input logic enable);
        if (clear_req) begin
            return ST_CLR_LOAD;
        end else if (enable) begin
            return ST_LOAD;
        end
        return ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_sequencer_if                                                          |
// | Segment ROM lookup plus start/done handshake towards the line drawer.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface line_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int COORD_W = line_pkg::COORD_W
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [COORD_W-1:0] rom_x0;
    logic [COORD_W-1:0] rom_y0;
    logic [COORD_W-1:0] rom_x1;
    logic [COORD_W-1:0] rom_y1;
    logic [COORD_W-1:0] drw_x0;
    logic [COORD_W-1:0] drw_y0;
    logic [COORD_W-1:0] drw_x1;
    logic [COORD_W-1:0] drw_y1;
    logic               drw_start;
    logic               drw_done;

    modport master (
        output rom_addr, drw_x0, drw_y0, drw_x1, drw_y1, drw_start,
        input  rom_x0, rom_y0, rom_x1, rom_y1, drw_done
    );

    modport slave (
        input  rom_addr, drw_x0, drw_y0, drw_x1, drw_y1, drw_start,
        output rom_x0, rom_y0, rom_x1, rom_y1, drw_done
    );
endinterface
`default_nettype wire

// File: rtl/line_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_sequencer                                                             |
// | Walks the segment ROM and full-screen clear rows through the line drawer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module line_sequencer
    import line_pkg::*;
#(
    parameter int NUM_SEGS = 37,
    parameter int ADDR_W   = 6,
    parameter int COORD_W  = line_pkg::COORD_W,
    parameter int SCREEN_W = line_pkg::SCREEN_W,
    parameter int SCREEN_H = line_pkg::SCREEN_H
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        enable,
    input  wire logic        clear_req,
    line_sequencer_if.master bus,
    output logic             pixel_color,
    output logic             busy,
    output logic             frame_done
);

    localparam int ROW_W = (SCREEN_H > 2) ? $clog2(SCREEN_H) : 1;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_SEGS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0] RIGHT_X   = COORD_W'(SCREEN_W - 1);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic               start_q, start_d;
    logic               color_q, color_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        row_d        = row_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        color_d      = color_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: state_d = pick_next(clear_req, enable);
            ST_LOAD: begin
                x0_d    = bus.rom_x0;
                y0_d    = bus.rom_y0;
                x1_d    = bus.rom_x1;
                y1_d    = bus.rom_y1;
                color_d = 1'b1;
                start_d = 1'b1;
                state_d = ST_START;
            end
            ST_START: state_d = ST_ARM;
            // The drawer may still show the previous line's done here.
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.drw_done) begin
                    state_d      = ST_NEXT;
                    frame_done_d = (rom_addr_q == LAST_ADDR);
                end
            end
            ST_NEXT: begin
                rom_addr_d = (rom_addr_q == LAST_ADDR) ? '0 : rom_addr_q + 1'b1;
                state_d    = pick_next(clear_req, enable);
            end
            ST_CLR_LOAD: begin
                x0_d    = '0;
                x1_d    = RIGHT_X;
                y0_d    = COORD_W'(row_q);
                y1_d    = COORD_W'(row_q);
                color_d = 1'b0;
                start_d = 1'b1;
                state_d = ST_CLR_START;
            end
            ST_CLR_START: state_d = ST_CLR_ARM;
            ST_CLR_ARM:   state_d = ST_CLR_WAIT;
            ST_CLR_WAIT: begin
                if (bus.drw_done) begin
                    if (row_q == LAST_ROW) begin
                        row_d      = '0;
                        rom_addr_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_CLR_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            row_q        <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            start_q      <= 1'b0;
            color_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            row_q        <= row_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            start_q      <= start_d;
            color_q      <= color_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.drw_x0    = x0_q;
    assign bus.drw_y0    = y0_q;
    assign bus.drw_x1    = x1_q;
    assign bus.drw_y1    = y1_q;
    assign bus.drw_start = start_q;
    assign pixel_color   = color_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_line_sequencer                                                          |
// | Randomised bench with a transaction-level model and a drawer responder.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_line_sequencer;
    import line_pkg::*;

    localparam int TB_NUM_SEGS = 37;
    localparam int TB_ADDR_W   = 6;
    localparam int TB_SCREEN_H = 4;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic enable    = 1'b0;
    logic clear_req = 1'b0;
    logic pixel_color, busy, frame_done;

    line_sequencer_if #(.ADDR_W(TB_ADDR_W), .COORD_W(COORD_W)) bus ();

    line_sequencer #(
        .NUM_SEGS (TB_NUM_SEGS),
        .ADDR_W   (TB_ADDR_W),
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (TB_SCREEN_H)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear_req   (clear_req),
        .bus         (bus),
        .pixel_color (pixel_color),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    logic [COORD_W-1:0] rom_x0_t [0:63];
    logic [COORD_W-1:0] rom_y0_t [0:63];
    logic [COORD_W-1:0] rom_x1_t [0:63];
    logic [COORD_W-1:0] rom_y1_t [0:63];
    assign bus.rom_x0 = rom_x0_t[bus.rom_addr];
    assign bus.rom_y0 = rom_y0_t[bus.rom_addr];
    assign bus.rom_x1 = rom_x1_t[bus.rom_addr];
    assign bus.rom_y1 = rom_y1_t[bus.rom_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drawer responder ----------------
    bit force_stale = 1'b0;
    int lat_fix     = 0;
    int drw_cnt     = 0;
    bit drw_pend    = 1'b0;

    initial begin
        bus.drw_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.drw_start === 1'b1) begin
                drw_cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
                if (force_stale || $urandom_range(0, 1) == 1) drw_pend = 1'b1;
                else bus.drw_done = 1'b0;
            end else if (drw_pend) begin
                bus.drw_done = 1'b0;
                drw_pend     = 1'b0;
            end else if (drw_cnt > 0) begin
                drw_cnt--;
                if (drw_cnt == 0) bus.drw_done = 1'b1;
            end
        end
    end

    // ---------------- behavioural model ----------------
    logic               m_busy, m_start, m_fd, m_color;
    logic [COORD_W-1:0] m_x0, m_y0, m_x1, m_y1;
    int                 m_addr, m_row;
    bit                 m_abort = 1'b0;

    task automatic set_reset_exp();
        m_busy = 0; m_start = 0; m_fd = 0; m_color = 0;
        m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
        m_addr = 0; m_row = 0;
    endtask

    always @(negedge reset_n) begin
        m_abort = 1'b1;
        set_reset_exp();
    end

    // Each @(posedge) below is one clock edge of the drawing protocol.
    task automatic run_seg();
        m_busy = 1;
        @(posedge clk); if (m_abort) return;
        m_x0 = rom_x0_t[m_addr]; m_y0 = rom_y0_t[m_addr];
        m_x1 = rom_x1_t[m_addr]; m_y1 = rom_y1_t[m_addr];
        m_color = 1; m_start = 1;
        @(posedge clk); if (m_abort) return;
        m_start = 0;
        @(posedge clk); if (m_abort) return;
        do begin
            @(posedge clk); if (m_abort) return;
        end while (bus.drw_done !== 1'b1);
        m_fd = (m_addr == TB_NUM_SEGS - 1);
    endtask

    task automatic run_clear();
        m_busy = 1;
        forever begin
            @(posedge clk); if (m_abort) return;
            m_x0 = 0; m_x1 = COORD_W'(SCREEN_W - 1);
            m_y0 = COORD_W'(m_row); m_y1 = COORD_W'(m_row);
            m_color = 0; m_start = 1;
            @(posedge clk); if (m_abort) return;
            m_start = 0;
            @(posedge clk); if (m_abort) return;
            do begin
                @(posedge clk); if (m_abort) return;
            end while (bus.drw_done !== 1'b1);
            if (m_row == TB_SCREEN_H - 1) begin
                m_row = 0; m_addr = 0; m_busy = 0;
                return;
            end
            m_row++;
        end
    endtask

    task automatic model_run();
        bit   after_seg;
        logic c, e;
        after_seg = 0;
        forever begin
            @(posedge clk); if (m_abort) return;
            c = clear_req; e = enable;
            if (after_seg) m_addr = (m_addr + 1) % TB_NUM_SEGS;
            m_fd = 0;
            if (c === 1'b1) begin
                run_clear(); if (m_abort) return;
                after_seg = 0;
            end else if (e === 1'b1) begin
                run_seg(); if (m_abort) return;
                after_seg = 1;
            end else begin
                m_busy = 0;
                after_seg = 0;
            end
        end
    endtask

    initial begin
        set_reset_exp();
        forever begin
            wait (reset_n === 1'b1);
            m_abort = 1'b0;
            model_run();
            set_reset_exp();
        end
    end

    always @(negedge clk) begin
        chk("busy",        32'(busy),          32'(m_busy));
        chk("drw_start",   32'(bus.drw_start), 32'(m_start));
        chk("frame_done",  32'(frame_done),    32'(m_fd));
        chk("pixel_color", 32'(pixel_color),   32'(m_color));
        chk("rom_addr",    32'(bus.rom_addr),  32'(m_addr));
        chk("drw_x0",      32'(bus.drw_x0),    32'(m_x0));
        chk("drw_y0",      32'(bus.drw_y0),    32'(m_y0));
        chk("drw_x1",      32'(bus.drw_x1),    32'(m_x1));
        chk("drw_y1",      32'(bus.drw_y1),    32'(m_y1));
    end

    // ---------------- start/frame monitor ----------------
    int cap_y[$], cap_x0[$], cap_x1[$], cap_col[$];
    int fd_cnt = 0;

    always @(negedge clk) begin
        if (bus.drw_start === 1'b1) begin
            cap_y.push_back(int'(bus.drw_y0));
            cap_x0.push_back(int'(bus.drw_x0));
            cap_x1.push_back(int'(bus.drw_x1));
            cap_col.push_back(int'(pixel_color));
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    // ---------------- directed + random sequence ----------------
    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < budget);
        chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n;
        n = 0;
        while (bus.drw_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_timeout"}, 32'(bus.drw_start), 32'd1);
    endtask

    initial begin
        int s0, f0, a, n;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int s0, f0, a, n;
        for (int i = 0; i < 64; i++) begin
            rom_x0_t[i] = COORD_W'($urandom_range(0, 2047));
            rom_y0_t[i] = COORD_W'($urandom_range(0, 2047));
            rom_x1_t[i] = COORD_W'($urandom_range(0, 2047));
            rom_y1_t[i] = COORD_W'($urandom_range(0, 2047));
        end
        rom_x0_t[0] = 11'd10; rom_y0_t[0] = 11'd20;
        rom_x1_t[0] = 11'd30; rom_y1_t[0] = 11'd40;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_start", 32'(bus.drw_start), 32'd0);
        chk("rst_color", 32'(pixel_color),   32'd0);
        chk("rst_fd",    32'(frame_done),    32'd0);
        chk("rst_addr",  32'(bus.rom_addr),  32'd0);
        chk("rst_x1",    32'(bus.drw_x1),    32'd0);
        reset_n = 1'b1;

        // Single segment, stale done, 4-cycle drawer
        force_stale = 1'b1; lat_fix = 4;
        @(negedge clk);
        s0 = cap_y.size();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(100, "single");
        chk("single_starts", 32'(cap_y.size() - s0), 32'd1);
        chk("single_x0",     32'(bus.drw_x0),       32'd10);
        chk("single_y0",     32'(bus.drw_y0),       32'd20);
        chk("single_x1",     32'(bus.drw_x1),       32'd30);
        chk("single_y1",     32'(bus.drw_y1),       32'd40);
        chk("single_color",  32'(pixel_color),      32'd1);
        chk("single_addr",   32'(bus.rom_addr),     32'd1);
        force_stale = 1'b0; lat_fix = 0;

        // Frame wrap
        f0 = fd_cnt;
        enable = 1'b1;
        n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_seen", 32'(frame_done), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("wrap_pulse", 32'(frame_done),   32'd0);
        chk("wrap_addr",  32'(bus.rom_addr), 32'd0);
        wait_idle(100, "wrap");
        chk("wrap_count", 32'(fd_cnt - f0), 32'd1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_idle(100, "wrap_next");
        chk("wrap_next_x0", 32'(bus.drw_x0), 32'd10);
        chk("wrap_next_y1", 32'(bus.drw_y1), 32'd40);

        // Full clear with reduced height
        s0 = cap_y.size();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_idle(400, "clear");
        chk("clear_starts", 32'(cap_y.size() - s0), 32'(TB_SCREEN_H));
        for (int r = 0; r < TB_SCREEN_H; r++) begin
            if (s0 + r < cap_y.size()) begin
                chk("clear_row_y",  32'(cap_y[s0 + r]),   32'(r));
                chk("clear_row_x0", 32'(cap_x0[s0 + r]),  32'd0);
                chk("clear_row_x1", 32'(cap_x1[s0 + r]),  32'd639);
                chk("clear_color",  32'(cap_col[s0 + r]), 32'd0);
            end
        end
        chk("clear_addr", 32'(bus.rom_addr), 32'd0);

        // Clear raised mid-line: line finishes, then clear starts
        lat_fix = 5;
        enable = 1'b1;
        @(negedge clk);
        wait_start(50, "prio");
        @(negedge clk);
        @(negedge clk);
        a = int'(bus.rom_addr);
        clear_req = 1'b1;
        enable    = 1'b0;
        @(negedge clk);
        wait_start(50, "prio_clr");
        chk("prio_color", 32'(pixel_color),   32'd0);
        chk("prio_row",   32'(bus.drw_y0),    32'd0);
        chk("prio_addr",  32'(bus.rom_addr),  32'((a + 1) % TB_NUM_SEGS));
        clear_req = 1'b0;
        wait_idle(400, "prio");
        chk("prio_end_addr", 32'(bus.rom_addr), 32'd0);

        // Reset in the middle of the line at address 5
        lat_fix = 6;
        enable = 1'b1;
        n = 0;
        while (!(bus.rom_addr == 6'd5 && bus.drw_start === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reach", 32'(bus.rom_addr), 32'd5);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(bus.rom_addr), 32'd0);
        chk("midrst_busy", 32'(busy),         32'd0);
        chk("midrst_x0",   32'(bus.drw_x0),   32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        lat_fix = 0;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 9) < 7);
            clear_req = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        enable = 1'b0; clear_req = 1'b0;
        wait_idle(400, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_sequencer.md
# line_sequencer

Initiator side of the line-drawer endpoint interface: walks the segment ROM, presents one segment at a time to `line_drawer` with a start/done handshake, and advances only after each line completes. It also owns screen clearing by issuing full-width black rows through the same drawer. It sits between `circle_rom` and `line_drawer` in the top level, replacing the ad hoc address counter there, and drives the framebuffer pixel colour.

## Interface
- `NUM_SEGS`, 37: segment entries in ROM; addresses 0..NUM_SEGS-1.
- `ADDR_W`, 6: ROM address width.
- `COORD_W`, 11: coordinate width; matches drawer and framebuffer.
- `SCREEN_W`, 640 / `SCREEN_H`, 480: clear sweep extent.

Ports:
- `clk`  in  1  drawer clock; the divided clock in the top level.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits drawing segments; sampled only in IDLE and NEXT.
- `clear_req`  in  1  level; requests a full-screen clear.
- `rom_addr`  out  ADDR_W  address to the combinational segment ROM.
- `rom_x0`, `rom_y0`, `rom_x1`, `rom_y1`  in  COORD_W each  ROM endpoints, valid in the same cycle as `rom_addr`.
- `drw_x0`, `drw_y0`, `drw_x1`, `drw_y1`  out  COORD_W each  registered endpoints to the drawer.
- `drw_start`  out  1  one-cycle start pulse.
- `drw_done`  in  1  drawer completion flag.
- `pixel_color`  out  1  1 = white (segment), 0 = black (clear).
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last segment completes.

## Operation
- **Drawer contract**
  - The drawer deasserts `drw_done` by the second cycle after `drw_start`.
  - It holds `drw_done` low while drawing.
  - It raises `drw_done` on completion and holds it high until the next start.
- **States**
  - IDLE:
    - `clear_req` → CLR_LOAD (clear has priority).
    - Else `enable` → LOAD.
    - Else stay.
  - LOAD: register ROM endpoints into `drw_*`; set `pixel_color`=1 → START.
  - START: `drw_start`=1 → ARM.
  - ARM: ignore `drw_done` → WAIT.
  - WAIT: stay until `drw_done`=1 → NEXT.
  - NEXT:
    - If `rom_addr` is NUM_SEGS-1: wrap `rom_addr` to 0 and pulse `frame_done`.
    - Else increment `rom_addr`.
    - Then apply the IDLE priority: `clear_req` → CLR_LOAD, else `enable` → LOAD, else → IDLE.
  - CLR_LOAD:
    - `drw_x0`=0, `drw_x1`=SCREEN_W-1, `drw_y0`=`drw_y1`=row.
    - `pixel_color`=0 → CLR_START.
  - CLR_START / CLR_ARM / CLR_WAIT: same as START / ARM / WAIT.
  - CLR_WAIT on done:
    - If row = SCREEN_H-1: row←0, `rom_addr`←0 → IDLE.
    - Else row←row+1 → CLR_LOAD.
- A clear always runs to completion; `clear_req` is not re-sampled mid-sweep.
- A line in flight is never aborted. `clear_req` or `enable` deasserting takes effect at the next NEXT or IDLE.
- Row counter: width to hold SCREEN_H-1 (9 bits); the value is zero-extended to COORD_W.
- `pixel_color` changes only in LOAD and CLR_LOAD. It is stable for the whole line.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0):
  - state IDLE.
  - `rom_addr`=0, row=0.
  - All `drw_*` coordinates = 0.
  - `drw_start`=0, `pixel_color`=0, `busy`=0, `frame_done`=0.
- Reset mid-line returns to IDLE. The drawer is reset independently.
- Latency:
  - `enable` high in IDLE → LOAD next cycle.
  - `drw_start` 2 cycles after leaving IDLE.
  - Earliest `drw_done` sample is 2 cycles after `drw_start`.
- Per-segment overhead: 5 cycles plus drawer time (LOAD, START, ARM, WAIT ≥1, NEXT).
- `frame_done` is asserted in the NEXT cycle that wraps the address.
- Simultaneous `clear_req` and `enable` → clear wins.

## Structure
- Package `line_pkg`: `COORD_W`, `SCREEN_W`, `SCREEN_H`, and the state enum `seq_state_t`.
- Single module; no sub-module. The row counter and address counter are inline registers.

## Test plan
- **Reset:** hold `reset_n`=0 → all outputs 0, state IDLE. Assert `reset_n`=0 during WAIT at `rom_addr`=5 → `rom_addr`=0 immediately.
- **Single segment:** `enable`=1, ROM[0]=(10,20,30,40), drawer model with 4-cycle done → `drw_*`=(10,20,30,40).
  - `drw_start` exactly once.
  - `pixel_color`=1.
  - `rom_addr`=1 after NEXT.
- **Wrap:** run with `enable`=1 through address 36 → `frame_done` one cycle, `rom_addr`=0. The next start uses ROM[0].
- **Stale done:** `drw_done` left high from the previous line, drawer drops it 2 cycles after start → sequencer does not advance early. Exactly one NEXT per start.
- **Clear:** `clear_req`=1 in IDLE, SCREEN_H reduced to 4 → 4 starts with rows y=0..3.
  - Each row spans x0=0, x1=639.
  - `pixel_color`=0 throughout.
  - Ends in IDLE with `rom_addr`=0.
- **Priority/no-abort:** raise `clear_req` and drop `enable` while in WAIT → the current line completes, then CLR_LOAD.
